ras_trace_checker: RTL and testbench

- Consumer stage directly downstream of the 36-bit trace FIFO in the RAS test harness.
- Pops call/return trace entries and replays them against a shadow return-address stack.
- Flags every return whose actual target differs from the predicted stack top.
- Exposes saturating statistics counters and first-error capture for the test controller.

---
 rtl/ras_trace_checker_pkg.sv | 34 +++
 rtl/ras_trace_checker_if.sv | 11 +
 rtl/ras_trace_checker_shadow_stack.sv | 46 ++++
 rtl/ras_trace_checker.sv | 145 ++++++++++++++
 tb/tb_ras_trace_checker.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/ras_trace_checker_pkg.sv
// Shared types for the RAS trace checker: opcodes, trace entry layout, FSM states
// and the saturating counter helper.
package ras_pkg;

  localparam int WIDTH       = 36;
  localparam int ADDR_W      = 32;
  localparam int STACK_DEPTH = 16;
  localparam int STACK_AW    = 4;
  localparam int CNT_W       = 16;

  typedef enum logic [3:0] {
    OP_CALL  = 4'h1,
    OP_RET   = 4'h2,
    OP_FLUSH = 4'h3,
    OP_END   = 4'hF
  } opcode_e;

  // Opcode is kept as raw bits so undefined encodings survive the cast
  typedef struct packed {
    logic [3:0]        opcode;
    logic [ADDR_W-1:0] addr;
  } trace_entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/ras_trace_checker_if.sv
// Trace FIFO read port: the FIFO (master) presents head/empty, the checker (slave) pops.
interface ras_trace_checker_if;

  logic                      fifo_empty;
  logic [ras_pkg::WIDTH-1:0] fifo_dout;
  logic                      fifo_pop;

  modport master (output fifo_empty, output fifo_dout, input fifo_pop);
  modport slave  (input fifo_empty, input fifo_dout, output fifo_pop);

endinterface

// File: rtl/ras_trace_checker_shadow_stack.sv
// Circular shadow return-address stack; a push when full overwrites the oldest entry.
module ras_shadow_stack #(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 16,
  parameter int AW     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              clear,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top,
  output logic [AW:0]       count,
  output logic              full,
  output logic              empty
);

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     top_ptr;

  assign top_ptr = wr_ptr - 1'b1;
  assign top     = mem[top_ptr];
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);

  always_ff @(posedge clk) begin
    if (!rst && !clear && push) mem[wr_ptr] <= push_data;
  end

  // When full, wr_ptr already sits on the oldest slot, so wrapping overwrites it
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (push) begin
      wr_ptr <= wr_ptr + 1'b1;
      if (!full) count <= count + 1'b1;
    end else if (pop && !empty) begin
      wr_ptr <= top_ptr;
      count  <= count - 1'b1;
    end
  end

endmodule

// File: rtl/ras_trace_checker.sv
// Replays call/return trace entries against a shadow stack and keeps statistics.
// Define RAS_CHK_STOP_ON_ERR_EN to end the run at the first return mismatch.
module ras_trace_checker
  import ras_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  ras_trace_checker_if.slave  fifo,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    entry_cnt,
  output logic [CNT_W-1:0]    call_cnt,
  output logic [CNT_W-1:0]    ret_cnt,
  output logic [CNT_W-1:0]    mismatch_cnt,
  output logic [CNT_W-1:0]    underflow_cnt,
  output logic [CNT_W-1:0]    overflow_cnt,
  output logic [CNT_W-1:0]    unknown_cnt,
  output logic                first_err_valid,
  output logic [CNT_W-1:0]    first_err_idx,
  output logic [ADDR_W-1:0]   first_err_exp,
  output logic [ADDR_W-1:0]   first_err_act
);

  state_e            state;
  trace_entry_t      entry;
  logic              pop_fire;
  logic              start_run;
  logic              is_call, is_ret, is_flush, is_end, is_unknown;
  logic              ret_miss;
  logic              stk_push, stk_pop, stk_clear;
  logic [ADDR_W-1:0] stk_top;
  logic [STACK_AW:0] stk_count;
  logic              stk_full, stk_empty;

  assign entry         = trace_entry_t'(fifo.fifo_dout);
  assign pop_fire      = (state == RUN) && !fifo.fifo_empty && !rst;
  assign fifo.fifo_pop = pop_fire;
  assign start_run     = start && (state != RUN);

  assign is_call    = pop_fire && (entry.opcode == OP_CALL);
  assign is_ret     = pop_fire && (entry.opcode == OP_RET);
  assign is_flush   = pop_fire && (entry.opcode == OP_FLUSH);
  assign is_end     = pop_fire && (entry.opcode == OP_END);
  assign is_unknown = pop_fire && !(entry.opcode inside {OP_CALL, OP_RET, OP_FLUSH, OP_END});
  assign ret_miss   = is_ret && !stk_empty && (entry.addr != stk_top);

  assign stk_push  = is_call;
  assign stk_pop   = is_ret && !stk_empty;
  assign stk_clear = start_run || is_flush;

  ras_shadow_stack #(
    .ADDR_W (ADDR_W),
    .DEPTH  (STACK_DEPTH),
    .AW     (STACK_AW)
  ) u_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (stk_push),
    .pop       (stk_pop),
    .clear     (stk_clear),
    .push_data (entry.addr),
    .top       (stk_top),
    .count     (stk_count),
    .full      (stk_full),
    .empty     (stk_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      busy            <= 1'b0;
      done            <= 1'b0;
      entry_cnt       <= '0;
      call_cnt        <= '0;
      ret_cnt         <= '0;
      mismatch_cnt    <= '0;
      underflow_cnt   <= '0;
      overflow_cnt    <= '0;
      unknown_cnt     <= '0;
      first_err_valid <= 1'b0;
      first_err_idx   <= '0;
      first_err_exp   <= '0;
      first_err_act   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state           <= RUN;
            busy            <= 1'b1;
            done            <= 1'b0;
            entry_cnt       <= '0;
            call_cnt        <= '0;
            ret_cnt         <= '0;
            mismatch_cnt    <= '0;
            underflow_cnt   <= '0;
            overflow_cnt    <= '0;
            unknown_cnt     <= '0;
            first_err_valid <= 1'b0;
            first_err_idx   <= '0;
            first_err_exp   <= '0;
            first_err_act   <= '0;
          end
        end
        RUN: begin
          if (pop_fire) entry_cnt <= sat_inc(entry_cnt);
          if (is_call) begin
            call_cnt <= sat_inc(call_cnt);
            if (stk_full) overflow_cnt <= sat_inc(overflow_cnt);
          end
          if (is_ret) begin
            ret_cnt <= sat_inc(ret_cnt);
            if (stk_count == '0) underflow_cnt <= sat_inc(underflow_cnt);
          end
          if (ret_miss) begin
            mismatch_cnt <= sat_inc(mismatch_cnt);
            if (!first_err_valid) begin
              first_err_valid <= 1'b1;
              first_err_idx   <= entry_cnt;
              first_err_exp   <= stk_top;
              first_err_act   <= entry.addr;
            end
`ifdef RAS_CHK_STOP_ON_ERR_EN
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
`endif
          end
          if (is_unknown) unknown_cnt <= sat_inc(unknown_cnt);
          if (is_end) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ras_trace_checker.sv
// Directed bench for ras_trace_checker with a queue-backed FIFO model.
module tb_ras_trace_checker;
  import ras_pkg::*;

  localparam logic [35:0] GARBAGE = {4'h2, 32'hDEAD_BEEF};

  logic clk = 1'b0;
  logic rst;
  logic start;
  always #5 clk = ~clk;

  ras_trace_checker_if fifo_if ();

  logic              busy, done;
  logic [CNT_W-1:0]  entry_cnt, call_cnt, ret_cnt, mismatch_cnt;
  logic [CNT_W-1:0]  underflow_cnt, overflow_cnt, unknown_cnt;
  logic              first_err_valid;
  logic [CNT_W-1:0]  first_err_idx;
  logic [ADDR_W-1:0] first_err_exp, first_err_act;

  ras_trace_checker dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .fifo            (fifo_if),
    .busy            (busy),
    .done            (done),
    .entry_cnt       (entry_cnt),
    .call_cnt        (call_cnt),
    .ret_cnt         (ret_cnt),
    .mismatch_cnt    (mismatch_cnt),
    .underflow_cnt   (underflow_cnt),
    .overflow_cnt    (overflow_cnt),
    .unknown_cnt     (unknown_cnt),
    .first_err_valid (first_err_valid),
    .first_err_idx   (first_err_idx),
    .first_err_exp   (first_err_exp),
    .first_err_act   (first_err_act)
  );

  logic [35:0] q[$];
  logic        hold = 1'b0;
  logic        pop_pending;
  int          n_chk = 0;
  int          n_pass = 0;

  // FIFO model: present head at negedge, sample pop mid-cycle, retire head at posedge
  always begin
    @(negedge clk);
    if (hold || q.size() == 0) begin
      fifo_if.fifo_empty = 1'b1;
      fifo_if.fifo_dout  = GARBAGE;
    end else begin
      fifo_if.fifo_empty = 1'b0;
      fifo_if.fifo_dout  = q[0];
    end
    #2 pop_pending = fifo_if.fifo_pop;
    @(posedge clk);
    if (pop_pending && q.size() > 0) q.delete(0);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [35:0] ent(input logic [3:0] op, input logic [31:0] a);
    return {op, a};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int i;
    i = 0;
    while (!done && i < budget) begin
      @(negedge clk);
      i++;
    end
    check({tag, "_done"}, 64'(done), 64'd1);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    q.push_back(ent(4'h1, 32'h1));
    tick(3);
    #3;
    check("rst_pop", 64'(fifo_if.fifo_pop), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_entry", 64'(entry_cnt), 64'd0);
    check("rst_ferr", 64'(first_err_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    tick(1);

    // 1: balanced call/return
    q.push_back(ent(4'h1, 32'h1000));
    q.push_back(ent(4'h1, 32'h2000));
    q.push_back(ent(4'h2, 32'h2000));
    q.push_back(ent(4'h2, 32'h1000));
    q.push_back(ent(4'hF, 32'h0));
    pulse_start();
    check("t1_busy", 64'(busy), 64'd1);
    wait_done("t1", 50);
    check("t1_call", 64'(call_cnt), 64'd2);
    check("t1_ret", 64'(ret_cnt), 64'd2);
    check("t1_miss", 64'(mismatch_cnt), 64'd0);
    check("t1_entry", 64'(entry_cnt), 64'd5);
    check("t1_busy_end", 64'(busy), 64'd0);

    // 2: return target mismatch
    q.push_back(ent(4'h1, 32'h100));
    q.push_back(ent(4'h2, 32'h104));
    q.push_back(ent(4'hF, 32'h0));
    pulse_start();
    wait_done("t2", 50);
    check("t2_miss", 64'(mismatch_cnt), 64'd1);
    check("t2_fvalid", 64'(first_err_valid), 64'd1);
    check("t2_fidx", 64'(first_err_idx), 64'd1);
    check("t2_fexp", 64'(first_err_exp), 64'h100);
    check("t2_fact", 64'(first_err_act), 64'h104);
`ifdef RAS_CHK_STOP_ON_ERR_EN
    check("t2_entry", 64'(entry_cnt), 64'd2);
    check("t2_left", 64'(q.size()), 64'd1);
`else
    check("t2_entry", 64'(entry_cnt), 64'd3);
    check("t2_left", 64'(q.size()), 64'd0);
`endif
    q.delete();
    tick(1);

    // 3: overflow by one, then unwind past the bottom
    for (int i = 0; i <= 16; i++) q.push_back(ent(4'h1, 32'(i)));
    for (int i = 16; i >= 0; i--) q.push_back(ent(4'h2, 32'(i)));
    q.push_back(ent(4'hF, 32'h0));
    pulse_start();
    check("t3_fvalid_clr", 64'(first_err_valid), 64'd0);
    wait_done("t3", 100);
    check("t3_call", 64'(call_cnt), 64'd17);
    check("t3_ret", 64'(ret_cnt), 64'd17);
    check("t3_ovf", 64'(overflow_cnt), 64'd1);
    check("t3_udf", 64'(underflow_cnt), 64'd1);
    check("t3_miss", 64'(mismatch_cnt), 64'd0);
    check("t3_entry", 64'(entry_cnt), 64'd35);

    // 4: flush, underflow and an undefined opcode
    q.push_back(ent(4'h1, 32'hA));
    q.push_back(ent(4'h3, 32'h0));
    q.push_back(ent(4'h2, 32'hA));
    q.push_back(ent(4'h7, 32'h55));
    q.push_back(ent(4'hF, 32'h0));
    pulse_start();
    wait_done("t4", 50);
    check("t4_udf", 64'(underflow_cnt), 64'd1);
    check("t4_unk", 64'(unknown_cnt), 64'd1);
    check("t4_miss", 64'(mismatch_cnt), 64'd0);
    check("t4_entry", 64'(entry_cnt), 64'd5);

    // 5: FIFO starved mid-run; a start during RUN is ignored
    q.push_back(ent(4'h1, 32'h50));
    pulse_start();
    tick(3);
    check("t5_entry_pre", 64'(entry_cnt), 64'd1);
    for (int i = 0; i < 10; i++) begin
      start = (i == 4);
      @(negedge clk);
      #3;
      check("t5_pop_idle", 64'(fifo_if.fifo_pop), 64'd0);
    end
    start = 1'b0;
    check("t5_entry_hold", 64'(entry_cnt), 64'd1);
    check("t5_call_hold", 64'(call_cnt), 64'd1);
    check("t5_busy", 64'(busy), 64'd1);
    @(negedge clk);
    q.push_back(ent(4'h2, 32'h50));
    q.push_back(ent(4'hF, 32'h0));
    wait_done("t5", 50);
    check("t5_entry", 64'(entry_cnt), 64'd3);
    check("t5_ret", 64'(ret_cnt), 64'd1);
    check("t5_miss", 64'(mismatch_cnt), 64'd0);
    check("t5_udf", 64'(underflow_cnt), 64'd0);

    // 6: reset mid-run, then a clean restart
    q.push_back(ent(4'h1, 32'h1));
    q.push_back(ent(4'h1, 32'h2));
    q.push_back(ent(4'h1, 32'h3));
    q.push_back(ent(4'h1, 32'h4));
    q.push_back(ent(4'hF, 32'h0));
    pulse_start();
    tick(1);
    check("t6_entry_pre", 64'(entry_cnt), 64'd1);
    rst = 1'b1;
    #3;
    check("t6_pop_rst", 64'(fifo_if.fifo_pop), 64'd0);
    @(negedge clk);
    check("t6_left", 64'(q.size()), 64'd4);
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_done", 64'(done), 64'd0);
    check("t6_entry", 64'(entry_cnt), 64'd0);
    check("t6_call", 64'(call_cnt), 64'd0);
    rst = 1'b0;
    q.delete();
    tick(2);
    q.push_back(ent(4'h1, 32'h60));
    q.push_back(ent(4'h2, 32'h60));
    q.push_back(ent(4'hF, 32'h0));
    pulse_start();
    wait_done("t6", 50);
    check("t6_entry2", 64'(entry_cnt), 64'd3);
    check("t6_call2", 64'(call_cnt), 64'd1);
    check("t6_ret2", 64'(ret_cnt), 64'd1);
    check("t6_miss2", 64'(mismatch_cnt), 64'd0);
    check("t6_fvalid2", 64'(first_err_valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
